// File: rtl/tiny32_io_arbiter.sv
// tiny32_io_arbiter
//   Two-master / one-slave arbiter for the tiny32 I/O bus. Master 0 is the
//   CPU, master 1 a DMA/debug engine. Round-robin: one IDLE arbitration cycle
//   precedes every grant, and the master that did not finish last wins a tie.
//
// Optional build macro: TINY32_IO_ARB_TIMEOUT_EN
//   Adds a slave-wait watchdog. After TIMEOUT_CYCLES un-ready grant cycles the
//   arbiter spends one TOUT cycle completing the transfer itself with read data
//   32'hFFFF_FFFF and a one-cycle bus_error pulse.
//
// Ports
//   clk, nreset          clock, asynchronous active-low reset
//   mN_io_req/nwr        master N request and direction (0 = write, 1 = read)
//   mN_io_address        master N address (ADDR_BITS)
//   mN_io_data_out       master N write data
//   mN_io_data_in        master N read data (holds when not owner)
//   mN_io_ready          master N completion strobe
//   s_io_*               slave side; a combinational copy of the owner's bus
//   grant                one-hot current owner, 00 when idle
//   bus_error            one-cycle pulse on a watchdog completion
module tiny32_io_arbiter #(
  parameter int ADDR_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 m0_io_req,
  input  logic                 m0_io_nwr,
  input  logic [ADDR_BITS-1:0] m0_io_address,
  input  logic [31:0]          m0_io_data_out,
  output logic [31:0]          m0_io_data_in,
  output logic                 m0_io_ready,
  input  logic                 m1_io_req,
  input  logic                 m1_io_nwr,
  input  logic [ADDR_BITS-1:0] m1_io_address,
  input  logic [31:0]          m1_io_data_out,
  output logic [31:0]          m1_io_data_in,
  output logic                 m1_io_ready,
  output logic                 s_io_req,
  output logic                 s_io_nwr,
  output logic [ADDR_BITS-1:0] s_io_address,
  output logic [31:0]          s_io_data_out,
  input  logic [31:0]          s_io_data_in,
  input  logic                 s_io_ready,
  output logic [1:0]           grant,
  output logic                 bus_error
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("tiny32_io_arbiter: TIMEOUT_CYCLES must be 2..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
`ifdef TINY32_IO_ARB_TIMEOUT_EN
    , TOUT = 2'd3
`endif
  } state_t;

  state_t      state, state_nxt;
  logic        last, last_nxt;     // master that completed most recently
  logic [31:0] m0_hold, m1_hold;   // read data shown while not the owner

`ifdef TINY32_IO_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
  logic        tout_own;           // owner of the grant that timed out
  logic        tmo_hit;
  assign tmo_hit = (tmo_cnt == TMO_LIMIT);
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      last    <= 1'b1;
      m0_hold <= '0;
      m1_hold <= '0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      m0_hold <= m0_io_data_in;
      m1_hold <= m1_io_data_in;
    end
  end

`ifdef TINY32_IO_ARB_TIMEOUT_EN
  // IDLE always precedes a grant, so clearing there is clearing on entry.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tmo_cnt  <= '0;
      tout_own <= 1'b0;
    end else begin
      if (state == IDLE)
        tmo_cnt <= '0;
      else if ((state == GNT0 || state == GNT1) && !s_io_ready)
        tmo_cnt <= tmo_cnt + 16'd1;
      if (state == GNT0)
        tout_own <= 1'b0;
      else if (state == GNT1)
        tout_own <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    grant         = 2'b00;
    s_io_req      = 1'b0;
    s_io_nwr      = 1'b0;
    s_io_address  = '0;
    s_io_data_out = '0;
    m0_io_ready   = 1'b0;
    m1_io_ready   = 1'b0;
    m0_io_data_in = m0_hold;
    m1_io_data_in = m1_hold;
    bus_error     = 1'b0;
    case (state)
      IDLE: begin
        if (m0_io_req && m1_io_req) state_nxt = last ? GNT0 : GNT1;
        else if (m0_io_req)         state_nxt = GNT0;
        else if (m1_io_req)         state_nxt = GNT1;
      end
      GNT0: begin
        grant         = 2'b01;
        s_io_req      = m0_io_req;
        s_io_nwr      = m0_io_nwr;
        s_io_address  = m0_io_address;
        s_io_data_out = m0_io_data_out;
        // gate with req so an aborting master never sees a stray ready
        m0_io_ready   = s_io_ready & m0_io_req;
        m0_io_data_in = s_io_data_in;
        if (!m0_io_req) state_nxt = IDLE;
        else if (s_io_ready) begin
          state_nxt = IDLE;
          last_nxt  = 1'b0;
        end
`ifdef TINY32_IO_ARB_TIMEOUT_EN
        else if (tmo_hit) state_nxt = TOUT;
`endif
      end
      GNT1: begin
        grant         = 2'b10;
        s_io_req      = m1_io_req;
        s_io_nwr      = m1_io_nwr;
        s_io_address  = m1_io_address;
        s_io_data_out = m1_io_data_out;
        m1_io_ready   = s_io_ready & m1_io_req;
        m1_io_data_in = s_io_data_in;
        if (!m1_io_req) state_nxt = IDLE;
        else if (s_io_ready) begin
          state_nxt = IDLE;
          last_nxt  = 1'b1;
        end
`ifdef TINY32_IO_ARB_TIMEOUT_EN
        else if (tmo_hit) state_nxt = TOUT;
`endif
      end
`ifdef TINY32_IO_ARB_TIMEOUT_EN
      TOUT: begin
        grant     = tout_own ? 2'b10 : 2'b01;
        bus_error = 1'b1;
        last_nxt  = tout_own;
        state_nxt = IDLE;
        if (tout_own) begin
          m1_io_ready   = 1'b1;
          m1_io_data_in = 32'hFFFF_FFFF;
        end else begin
          m0_io_ready   = 1'b1;
          m0_io_data_in = 32'hFFFF_FFFF;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/tiny32_io_arbiter.md
Name: tiny32_io_arbiter

Overview:
- Two-master, one-slave arbiter for the tiny32 I/O bus (io_req / io_nwr / io_address / io_data / io_ready handshake).
- Master 0 is the tiny32 CPU; master 1 is a DMA or debug engine. The slave is the shared peripheral decode fabric.
- Round-robin grant with one arbitration cycle per transaction.
- Optional slave-timeout watchdog returns a bus error instead of hanging the CPU.

Parameters:
- ADDR_BITS, 32, width of io_address on all ports.
- TIMEOUT_CYCLES, 255, slave-wait cycles before forced completion (timeout build only); legal range 2..65535.

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- m0_io_req  in  1  master 0 request
- m0_io_nwr  in  1  master 0 direction: 0 = write, 1 = read
- m0_io_address  in  ADDR_BITS  master 0 address
- m0_io_data_out  in  32  master 0 write data
- m0_io_data_in  out  32  master 0 read data
- m0_io_ready  out  1  master 0 completion
- m1_io_req, m1_io_nwr, m1_io_address, m1_io_data_out, m1_io_data_in, m1_io_ready  same widths and meaning as m0 ports, for master 1
- s_io_req  out  1  slave request
- s_io_nwr  out  1  slave direction
- s_io_address  out  ADDR_BITS  slave address
- s_io_data_out  out  32  slave write data
- s_io_data_in  in  32  slave read data
- s_io_ready  in  1  slave completion
- grant  out  2  one-hot current owner; 00 = idle
- bus_error  out  1  one-cycle pulse on timeout

Behaviour:
- Clocking and reset: single clk domain. nreset low asynchronously forces:
  - state = IDLE, grant = 00, last = 1 (master 0 wins the first tie), timeout counter = 0.
  - All outputs 0: s_io_req, m*_io_ready, bus_error, s_io_address, s_io_data_out, m*_io_data_in.
- Master protocol: a master holds req, nwr, address and data stable until it sees io_ready = 1 for one cycle. It may re-assert req in the cycle after ready for a back-to-back transfer.
- States: IDLE, GNT0, GNT1, TOUT.
- IDLE:
  - s_io_req = 0; no io_ready is asserted.
  - Next state on the clock edge:
    - Only m0 requesting -> GNT0.
    - Only m1 requesting -> GNT1.
    - Both requesting -> the master other than `last`.
    - Neither -> stay in IDLE.
- GNT0 / GNT1:
  - grant is one-hot for the owner.
  - s_io_req/nwr/address/data_out are combinational copies of the owner's signals.
  - Owner io_ready = s_io_ready. Owner io_data_in = s_io_data_in. Non-owner io_ready = 0.
  - Non-owner io_data_in holds its last value.
  - When s_io_ready = 1: transaction done; last <= owner; next state IDLE.
  - If the owner drops req before ready: abort; next state IDLE; last is unchanged; no ready is issued.
- Latency:
  - One arbitration cycle plus slave latency.
  - With a zero-wait slave (s_io_ready tied 1), ready appears in the cycle after req is first sampled.
  - Maximum throughput is one transfer per 2 cycles.
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1...
- Simultaneous events:
  - A request from the non-owner during GNTx is held off. It is served in the very next grant.
  - Owner ready and a new request from the same owner in the same cycle: arbitration is re-run in IDLE. The other master wins if it is requesting.
- Reset mid-transfer: the transfer is dropped immediately. s_io_req falls asynchronously and no ready is issued.

Optional Feature:
- Macro: TINY32_IO_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on entry to GNTx and increments each GNTx cycle with s_io_ready = 0.
  - When the counter reaches TIMEOUT_CYCLES-1 with s_io_ready still 0, next state is TOUT.
  - TOUT lasts one cycle:
    - s_io_req = 0.
    - Owner io_ready = 1 and owner io_data_in = 32'hFFFF_FFFF (reads and writes alike).
    - bus_error = 1.
    - last <= owner.
    - Next state IDLE.
  - s_io_ready arriving on the same cycle the limit is reached wins: normal completion, no error.
- Without the macro: no counter and no TOUT state; bus_error is tied 0; GNTx waits indefinitely.

Test Plan:
- Zero-wait slave; m0 reads addr 0x1000 and slave returns 0x12345678 -> s_io_req high 1 cycle, m0_io_ready 1 cycle later, m0_io_data_in = 0x12345678, grant 01 -> 00.
- Both masters request continuously for 8 transfers, zero-wait slave -> grant sequence 01,10,01,10...; 4 completions each; no cycle with both ready.
- Slave inserts 3 wait states on an m1 write of 0xCAFEBABE to 0x20 -> s_io_data_out = 0xCAFEBABE stable for 4 cycles; m1_io_ready asserted only in the 4th; m0 held off, then granted next.
- Timeout build, TIMEOUT_CYCLES = 4, slave never ready, m0 read -> ready after 4 wait cycles plus TOUT; m0_io_data_in = 0xFFFFFFFF; bus_error pulses exactly 1 cycle; arbiter returns to IDLE.
- nreset pulled low for 1 cycle mid-GNT1 wait state -> s_io_req and grant drop to 0 without a clock edge; after release m0 wins the first tie.
- m0 drops req during a wait state -> no m0_io_ready; state returns to IDLE; pending m1 granted next cycle.
